multicycle_control: RTL and testbench

- Main control FSM for the multicycle MIPS core.
- Decodes the 6-bit opcode from the instruction register and sequences fetch, decode, execute, memory and writeback.
- Drives the datapath mux selects and write strobes.
- Produces the 2-bit aluop consumed by alu_control in Execute (00 add, 01 sub, 10 funct-decoded).

---
 rtl/multicycle_control.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control
//   Main control FSM of the multicycle MIPS core. Sequences each instruction
//   through fetch, decode, execute, memory and writeback. It also drives the
//   datapath mux selects and write strobes, plus the 2-bit aluop used by
//   alu_control.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   opcode     in   instr[31:26] from the instruction register
//   mem_ready  in   memory completes the current access this cycle
//   aluop      out  00 add, 01 sub, 10 funct-decoded
//   alusrca    out  0=PC, 1=rs
//   alusrcb    out  00=rt, 01=4, 10=sign-ext imm, 11=imm<<2
//   iord       out  memory address: 0=PC, 1=ALUOut
//   pcsrc      out  00=ALU result, 01=ALUOut, 10=jump target
//   regdst     out  0=rt, 1=rd
//   memtoreg   out  0=ALUOut, 1=MDR
//   irwrite, pcwrite, branch, regwrite, memwrite  out  write strobes
//   illegal_op out  one-cycle pulse in DECODE on an unsupported opcode
//   state      out  current state, for debug
module multicycle_control #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 2,
  parameter int ST_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic               mem_ready,
  output logic [ALUOP_W-1:0] aluop,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic               iord,
  output logic [1:0]         pcsrc,
  output logic               regdst,
  output logic               memtoreg,
  output logic               irwrite,
  output logic               pcwrite,
  output logic               branch,
  output logic               regwrite,
  output logic               memwrite,
  output logic               illegal_op,
  output logic [ST_W-1:0]    state
);

  typedef enum logic [ST_W-1:0] {
    S_FETCH  = ST_W'(0),
    S_DECODE = ST_W'(1),
    S_MEMADR = ST_W'(2),
    S_MEMRD  = ST_W'(3),
    S_MEMWB  = ST_W'(4),
    S_MEMWR  = ST_W'(5),
    S_EXEC   = ST_W'(6),
    S_ALUWB  = ST_W'(7),
    S_BRANCH = ST_W'(8),
    S_ADDIEX = ST_W'(9),
    S_ADDIWB = ST_W'(10),
    S_JUMP   = ST_W'(11)
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = ALUOP_W'(2);

  state_t state_q;
  state_t state_d;
  logic   op_known;

  assign op_known = (opcode == OP_LW)   || (opcode == OP_SW)   ||
                    (opcode == OP_RTYPE)|| (opcode == OP_BEQ)  ||
                    (opcode == OP_ADDI) || (opcode == OP_J);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; opcode is only consulted in DECODE and MEMADR.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if ((opcode == OP_LW) || (opcode == OP_SW)) state_d = S_MEMADR;
        else if (opcode == OP_RTYPE)                state_d = S_EXEC;
        else if (opcode == OP_BEQ)                  state_d = S_BRANCH;
        else if (opcode == OP_ADDI)                 state_d = S_ADDIEX;
        else if (opcode == OP_J)                    state_d = S_JUMP;
        else                                        state_d = S_FETCH;
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore output decode. FETCH strobes follow mem_ready so the IR and PC
  // only load on the cycle the instruction word actually arrives.
  always_comb begin
    aluop      = ALUOP_ADD;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    iord       = 1'b0;
    pcsrc      = 2'b00;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        illegal_op = !op_known;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD:  iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    // While reset is held the state already reads FETCH, but mem_ready
    // must not leak through to the strobes.
    if (!rst_n) begin
      irwrite    = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      regwrite   = 1'b0;
      memwrite   = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic [1:0] aluop;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       iord;
  logic [1:0] pcsrc;
  logic       regdst, memtoreg;
  logic       irwrite, pcwrite, branch, regwrite, memwrite, illegal_op;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0]  q_st[$];
  logic [15:0] q_out[$];

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .aluop(aluop), .alusrca(alusrca), .alusrcb(alusrcb), .iord(iord),
    .pcsrc(pcsrc), .regdst(regdst), .memtoreg(memtoreg),
    .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch),
    .regwrite(regwrite), .memwrite(memwrite), .illegal_op(illegal_op),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector from the state table:
  // {aluop, alusrca, alusrcb, iord, pcsrc, regdst, memtoreg,
  //  irwrite, pcwrite, branch, regwrite, memwrite, illegal_op}
  function automatic logic [15:0] expect_out(input logic [3:0] st, input logic mr,
                                             input logic ill, input logic rn);
    logic [1:0] a_op, src_b, pc_s;
    logic src_a, io, rd, m2r, irw, pcw, br, rw, mw, il;
    a_op = 2'b00; src_b = 2'b00; pc_s = 2'b00;
    src_a = 0; io = 0; rd = 0; m2r = 0; irw = 0; pcw = 0; br = 0; rw = 0; mw = 0; il = 0;
    case (st)
      4'd0:  begin src_b = 2'b01; irw = mr; pcw = mr; end
      4'd1:  begin src_b = 2'b11; il = ill; end
      4'd2:  begin src_a = 1; src_b = 2'b10; end
      4'd3:  io = 1;
      4'd4:  begin m2r = 1; rw = 1; end
      4'd5:  begin io = 1; mw = 1; end
      4'd6:  begin src_a = 1; a_op = 2'b10; end
      4'd7:  begin rd = 1; rw = 1; end
      4'd8:  begin src_a = 1; a_op = 2'b01; pc_s = 2'b01; br = 1; end
      4'd9:  begin src_a = 1; src_b = 2'b10; end
      4'd10: rw = 1;
      4'd11: begin pc_s = 2'b10; pcw = 1; end
      default: ;
    endcase
    if (!rn) begin irw = 0; pcw = 0; br = 0; rw = 0; mw = 0; il = 0; end
    return {a_op, src_a, src_b, io, pc_s, rd, m2r, irw, pcw, br, rw, mw, il};
  endfunction

  task automatic push_exp(input logic [3:0] st, input logic mr, input logic ill,
                          input logic rn);
    q_st.push_back(st);
    q_out.push_back(expect_out(st, mr, ill, rn));
  endtask

  task automatic compare(input string tag);
    logic [15:0] obs, exp_o;
    logic [3:0]  exp_s;
    if (q_st.size() == 0 || q_out.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s scoreboard empty: obs=none exp=entry", tag);
      return;
    end
    exp_s = q_st.pop_front();
    exp_o = q_out.pop_front();
    obs = {aluop, alusrca, alusrcb, iord, pcsrc, regdst, memtoreg,
           irwrite, pcwrite, branch, regwrite, memwrite, illegal_op};
    n_tests++;
    assert (state === exp_s) else begin
      n_fail++;
      $error("FAIL %s state obs=%0d exp=%0d", tag, state, exp_s);
    end
    n_tests++;
    assert (obs === exp_o) else begin
      n_fail++;
      $error("FAIL %s outputs obs=%b exp=%b", tag, obs, exp_o);
    end
    n_tests++;
    assert ((regwrite & memwrite) === 1'b0) else begin
      n_fail++;
      $error("FAIL %s regwrite_with_memwrite obs=1 exp=0", tag);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check mid-cycle.
  task automatic cyc(input logic [3:0] st, input logic mr, input logic [5:0] op,
                     input logic ill, input string tag);
    mem_ready = mr;
    opcode    = op;
    push_exp(st, mr, ill, 1'b1);
    #2;
    compare(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: run did not reach summary");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; opcode = R;
    #2;
    push_exp(4'd0, 1'b1, 1'b0, 1'b0);
    compare("reset_hold");
    @(posedge clk); #1;
    push_exp(4'd0, 1'b1, 1'b0, 1'b0);
    compare("reset_edge");
    rst_n = 1'b1;

    // R-type
    cyc(4'd0, 1, R, 0, "r_fetch");
    cyc(4'd1, 1, R, 0, "r_decode");
    cyc(4'd6, 1, R, 0, "r_exec");
    cyc(4'd7, 1, R, 0, "r_aluwb");

    // lw with two wait cycles in MEMRD
    cyc(4'd0, 1, LW, 0, "lw_fetch");
    cyc(4'd1, 1, LW, 0, "lw_decode");
    cyc(4'd2, 1, LW, 0, "lw_memadr");
    cyc(4'd3, 0, LW, 0, "lw_memrd_w0");
    cyc(4'd3, 0, LW, 0, "lw_memrd_w1");
    cyc(4'd3, 1, LW, 0, "lw_memrd");
    cyc(4'd4, 1, LW, 0, "lw_memwb");

    // sw
    cyc(4'd0, 1, SW, 0, "sw_fetch");
    cyc(4'd1, 1, SW, 0, "sw_decode");
    cyc(4'd2, 1, SW, 0, "sw_memadr");
    cyc(4'd5, 1, SW, 0, "sw_memwr");

    // beq
    cyc(4'd0, 1, BEQ, 0, "beq_fetch");
    cyc(4'd1, 1, BEQ, 0, "beq_decode");
    cyc(4'd8, 1, BEQ, 0, "beq_branch");

    // j
    cyc(4'd0, 1, J, 0, "j_fetch");
    cyc(4'd1, 1, J, 0, "j_decode");
    cyc(4'd11, 1, J, 0, "j_jump");

    // addi
    cyc(4'd0, 1, ADDI, 0, "addi_fetch");
    cyc(4'd1, 1, ADDI, 0, "addi_decode");
    cyc(4'd9, 1, ADDI, 0, "addi_ex");
    cyc(4'd10, 1, ADDI, 0, "addi_wb");

    // unsupported opcode
    cyc(4'd0, 1, BAD, 0, "ill_fetch");
    cyc(4'd1, 1, BAD, 1, "ill_decode");
    cyc(4'd0, 0, BAD, 0, "ill_back_to_fetch");

    // fetch stalled by memory for three cycles
    cyc(4'd0, 0, R, 0, "fetch_w1");
    cyc(4'd0, 0, R, 0, "fetch_w2");
    cyc(4'd0, 1, R, 0, "fetch_go");
    cyc(4'd1, 1, R, 0, "stall_decode");

    // reset asserted in the middle of EXEC
    mem_ready = 1'b1;
    opcode    = R;
    push_exp(4'd6, 1'b1, 1'b0, 1'b1);
    #2;
    compare("pre_rst_exec");
    #1;
    rst_n = 1'b0;
    #1;
    push_exp(4'd0, 1'b1, 1'b0, 1'b0);
    compare("rst_mid_exec");
    @(posedge clk); #1;
    push_exp(4'd0, 1'b1, 1'b0, 1'b0);
    compare("rst_mid_edge");
    rst_n = 1'b1;
    cyc(4'd0, 1, R, 0, "post_rst_fetch");
    cyc(4'd1, 1, R, 0, "post_rst_decode");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
